// File: rtl/ticket_caller.sv
// Queue caller: counts issued tickets and hands them, in order, to counter buttons A..E.
// Arbitration: fixed priority (A highest) by default, round-robin when ROUND_ROBIN_EN is defined.
module ticket_caller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] issued_number,
    input  logic [4:0] free_btn,
    output logic       call_valid,
    output logic [5:0] call_number,
    output logic [2:0] call_counter,
    output logic [5:0] A_serviceNumber,
    output logic [5:0] B_serviceNumber,
    output logic [5:0] C_serviceNumber,
    output logic [5:0] D_serviceNumber,
    output logic [5:0] E_serviceNumber,
    output logic [5:0] waiting
);

    logic [5:0]      prev_issued;
    logic [4:0]      prev_btn;
    logic [4:0]      pend;
    logic [4:0]      pend_next;
    logic [5:0]      next_to_call;
    logic [5:0]      waiting_next;
    logic [4:0][5:0] svc;
    logic            new_ticket;
    logic [4:0]      btn_rise;
    logic            grant_any;
    logic [2:0]      grant_idx;
    logic [4:0]      grant_mask;

    assign A_serviceNumber = svc[0];
    assign B_serviceNumber = svc[1];
    assign C_serviceNumber = svc[2];
    assign D_serviceNumber = svc[3];
    assign E_serviceNumber = svc[4];

    assign new_ticket = (issued_number != prev_issued);
    assign btn_rise   = free_btn & ~prev_btn;

    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
`ifdef ROUND_ROBIN_EN
        begin
            // call_counter holds the last grant as 1..5 (0 after reset), which is
            // exactly the 0-based index where the search should begin.
            int unsigned start;
            int unsigned idx;
            start = (call_counter >= 3'd5) ? 0 : int'(call_counter);
            for (int unsigned k = 0; k < 5; k++) begin
                idx = start + k;
                if (idx >= 5) idx = idx - 5;
                if (!grant_any && pend[idx] && (waiting != '0)) begin
                    grant_any = 1'b1;
                    grant_idx = 3'(idx);
                end
            end
        end
`else
        for (int unsigned k = 0; k < 5; k++) begin
            if (!grant_any && pend[k] && (waiting != '0)) begin
                grant_any = 1'b1;
                grant_idx = 3'(k);
            end
        end
`endif
        if (grant_any) grant_mask[grant_idx] = 1'b1;
    end

    // A rise on an already-pending counter is dropped, including the granted one.
    assign pend_next = (pend & ~grant_mask) | (btn_rise & ~pend);

    always_comb begin
        waiting_next = waiting;
        if (new_ticket && !grant_any) begin
            if (waiting != 6'd63) waiting_next = waiting + 6'd1;
        end else if (grant_any && !new_ticket) begin
            waiting_next = waiting - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_issued  <= '0;
            prev_btn     <= '1;
            pend         <= '0;
            waiting      <= '0;
            next_to_call <= 6'd1;
            call_valid   <= 1'b0;
            call_number  <= '0;
            call_counter <= '0;
            svc          <= '0;
        end else begin
            prev_issued <= issued_number;
            prev_btn    <= free_btn;
            pend        <= pend_next;
            waiting     <= waiting_next;
            call_valid  <= grant_any;
            if (grant_any) begin
                call_number    <= next_to_call;
                call_counter   <= grant_idx + 3'd1;
                svc[grant_idx] <= next_to_call;
                next_to_call   <= (next_to_call == 6'd63) ? 6'd1 : next_to_call + 6'd1;
            end
        end
    end

endmodule

// File: doc/ticket_caller.md
TICKET_CALLER -- requirements
Module: ticket_caller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 issued_number  input  6  last ticket issued by the dispenser; 0 = none issued; valid values 1..63, wrapping 63->1.
REQ-005 free_btn  input  5  per-counter "next customer" buttons; bit0=A .. bit4=E; level input.
REQ-006 call_valid  output  1  one-cycle pulse, a customer is being called.
REQ-007 call_number  output  6  ticket number called; holds last value between pulses.
REQ-008 call_counter  output  3  counter called to; 1..5 = A..E; 0 = none since reset.
REQ-009 A_serviceNumber..E_serviceNumber  output  6 each  ticket currently served at each counter; 0 = idle since reset.
REQ-010 waiting  output  6  tickets issued but not yet called.

Function
REQ-011 New-ticket detect: issued_number differing from its registered previous value counts as exactly one new ticket.
REQ-012 Button detect: free_btn bit sampled 1 with previous sample 0 sets that counter's pend bit on the same edge.
REQ-013 A rising edge on a counter whose pend bit is already set SHALL be ignored.
REQ-014 Grant: on an edge where waiting>0 and any pend bit is set, exactly one counter is granted.
REQ-015 On grant, the following SHALL all happen on the same edge:
- call_valid=1 for that cycle only
- call_number=next_to_call
- call_counter=granted index
- granted serviceNumber=next_to_call
- granted pend bit cleared
- next_to_call advanced (63 wraps to 1)
REQ-016 Latency: with waiting>0, call_valid SHALL rise one cycle after the edge that set pend.
REQ-017 waiting SHALL:
- increment on a new ticket
- decrement on a grant
- stay unchanged when both occur on the same edge
- saturate at 63 (new tickets beyond 63 dropped)
REQ-018 With waiting=0, pend bits SHALL persist until tickets arrive; a ticket arriving with pend set SHALL be granted on the following edge.
REQ-019 Pend set and grant for the same counter on the same edge: the grant uses the previously latched pend; the new edge is ignored per REQ-013.
REQ-020 At most one grant per clock cycle.

Reset
REQ-021 While rst=1:
- call_valid, call_number, call_counter, all serviceNumbers, waiting, pend = 0
- next_to_call = 1
- previous issued_number register = 0
- previous free_btn register = 5'b11111 (buttons held through reset do not request)
REQ-022 Reset asserted mid-operation SHALL discard all pending requests and the waiting count immediately, without waiting for a clock edge.

Configuration
REQ-023 Macro ROUND_ROBIN_EN selects the arbitration scheme:
- Defined: round-robin arbitration starting after the last granted counter (A after E); first grant after reset starts search at A.
- Undefined: fixed priority, A highest, E lowest.

Verification
REQ-024 Reset, issued_number 0->1, pulse free_btn[0] -> call_valid one cycle; call_number=1, call_counter=1, A_serviceNumber=1, waiting 1->0.
REQ-025 Three tickets issued, then free_btn A and C rise on the same edge:
- ROUND_ROBIN_EN undefined -> A gets 1, next cycle C gets 2, waiting=1
- ROUND_ROBIN_EN defined, last grant was A -> C first
REQ-026 waiting=0, press B, then issue ticket 5 -> no call while empty; call_valid one cycle after the ticket edge, B_serviceNumber=5.
REQ-027 next_to_call=63 with two tickets waiting, two grants -> call_numbers 63 then 1.
REQ-028 New ticket and grant on the same edge -> waiting unchanged.
REQ-029 Raise rst between two button presses -> all outputs 0 asynchronously; a held button does not call after rst falls.
